// File: rtl/motor_pkg.sv
// motor_pkg
//   Shared definitions for the motor position controller: FSM state
//   encodings and step-direction codes driven onto stepDir.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } motor_state_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/motor_step_timer.sv
// motor_step_timer
//   Down-counter that sets the spacing between step pulses. A load presets
//   the count to STEP_INTERVAL-2, which together with the STEP cycle and the
//   cycle that spends the terminal count gives exactly STEP_INTERVAL cycles
//   from one step pulse to the next.
// Ports
//   clk     in  clock, rising edge
//   reset   in  synchronous, active-high; clears the count
//   load    in  preset the count to STEP_INTERVAL-2
//   enable  in  count down by one per cycle while non-zero
//   done    out count has reached zero (terminal count)
module motor_step_timer #(
    parameter int STEP_INTERVAL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = $clog2(STEP_INTERVAL);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STEP_INTERVAL - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/motor_position_ctrl.sv
// motor_position_ctrl
//   Holds a desired position on a ring of 2**POS_WIDTH angles and steps a
//   step/dir motor toward it along the shortest path, one pulse at most every
//   STEP_INTERVAL cycles. A stall fault is raised after STALL_LIMIT
//   consecutive steps that leave physicalPos unchanged.
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   moveCW       in   desiredPos + 1 (mod N)
//   moveCCW      in   desiredPos - 1 (mod N); with moveCW together = hold
//   load         in   desiredPos <= loadPos (wins over moves); leaves FAULT
//   loadPos      in   target for load
//   physicalPos  in   measured motor position
//   desiredPos   out  registered target
//   posError     out  desiredPos - physicalPos, two's complement
//   stepPulse    out  one-cycle step request
//   stepDir      out  1 = CW, 0 = CCW, qualified by stepPulse
//   atTarget     out  idle with zero error
//   fault        out  stall detected
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | on target or waiting for an error to appear
// STEP  | pulse cycle; direction latched from error sign, position sampled
// WAIT  | step interval timing; stall check at terminal count
// FAULT | motor not following; only load leaves
module motor_position_ctrl
    import motor_pkg::*;
#(
    parameter int POS_WIDTH     = 3,
    parameter int STEP_INTERVAL = 4,
    parameter int STALL_LIMIT   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 moveCW,
    input  logic                 moveCCW,
    input  logic                 load,
    input  logic [POS_WIDTH-1:0] loadPos,
    input  logic [POS_WIDTH-1:0] physicalPos,
    output logic [POS_WIDTH-1:0] desiredPos,
    output logic [POS_WIDTH-1:0] posError,
    output logic                 stepPulse,
    output logic                 stepDir,
    output logic                 atTarget,
    output logic                 fault
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [POS_WIDTH-1:0] POS_ONE   = POS_WIDTH'(1);
    localparam logic [STALL_W-1:0]   STALL_ONE = STALL_W'(1);
    localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT);

    motor_state_t         state_q, state_d;
    logic [POS_WIDTH-1:0] desired_q;
    logic [POS_WIDTH-1:0] last_pos_q;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 err_zero, err_neg;
    logic                 timer_load, timer_en, timer_done;

    // Target register. Commands are honoured in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            desired_q <= physicalPos;
        end else if (load) begin
            desired_q <= loadPos;
        end else if (moveCW ^ moveCCW) begin
            desired_q <= moveCW ? (desired_q + POS_ONE) : (desired_q - POS_ONE);
        end
    end

    // Modular difference read as signed: the MSB selects the shorter way
    // round, and the half-ring case (-N/2) falls to CCW.
    assign posError = desired_q - physicalPos;
    assign err_zero = (posError == '0);
    assign err_neg  = posError[POS_WIDTH-1];

    motor_step_timer #(
        .STEP_INTERVAL(STEP_INTERVAL)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .enable (timer_en),
        .done   (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stall_q    <= '0;
            last_pos_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            if (state_q == ST_STEP) begin
                last_pos_q <= physicalPos;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!err_zero) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                timer_load = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                if (timer_done) begin
                    stall_d = (physicalPos == last_pos_q) ? (stall_q + STALL_ONE) : '0;
                    if (stall_d == STALL_MAX) begin
                        state_d = ST_FAULT;
                    end else if (err_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_FAULT: begin
                if (load) begin
                    state_d = ST_IDLE;
                    stall_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign desiredPos = desired_q;
    assign stepPulse  = (state_q == ST_STEP);
    // A pulse already committed while the error went to zero is sent as CCW.
    assign stepDir    = (stepPulse && !err_neg && !err_zero) ? DIR_CW : DIR_CCW;
    assign atTarget   = (state_q == ST_IDLE) && err_zero;
    assign fault      = (state_q == ST_FAULT);

endmodule
